alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 45 ++++
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle between two requesters, the arbiter and the shared ALU stage.
//   master : requester/ALU side, drives req*, operands, ALU_out, zero
//   slave  : arbiter side, drives latched operands/controls, grants,
//            done pulses, captured result and busy
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned FUNC_W = 4;

  // Requester side
  logic              req0, req1;
  logic [DATA_W-1:0] a0, a1;
  logic [DATA_W-1:0] b0, b1;
  logic [DATA_W-1:0] imm0, imm1;
  logic              bsel0, bsel1;
  logic [FUNC_W-1:0] func0, func1;

  // Shared ALU stage
  logic [DATA_W-1:0] rfa, rfb, immed;
  logic              ALU_bin_sel;
  logic [FUNC_W-1:0] ALU_func;
  logic [DATA_W-1:0] ALU_out;
  logic              zero;

  // Handshake / result
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic [DATA_W-1:0] res;
  logic              res_zero;
  logic              busy;

  modport master (
    output req0, req1, a0, a1, b0, b1, imm0, imm1, bsel0, bsel1, func0, func1,
    output ALU_out, zero,
    input  rfa, rfb, immed, ALU_bin_sel, ALU_func,
    input  gnt0, gnt1, done0, done1, res, res_zero, busy
  );

  modport slave (
    input  req0, req1, a0, a1, b0, b1, imm0, imm1, bsel0, bsel1, func0, func1,
    input  ALU_out, zero,
    output rfa, rfb, immed, ALU_bin_sel, ALU_func,
    output gnt0, gnt1, done0, done1, res, res_zero, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU stage between two requesters.
// Each operation takes IDLE -> EXEC (gnt pulse) -> DONE (done pulse).
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : alu_arbiter_if.slave (requests, operands, ALU result, outputs)
module alu_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  localparam int unsigned FUNC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              owner_q;
  logic              last_owner_q;
  logic [DATA_W-1:0] rfa_q, rfb_q, immed_q, res_q;
  logic              bsel_q;
  logic [FUNC_W-1:0] func_q;
  logic              gnt0_q, gnt1_q, done0_q, done1_q;
  logic              res_zero_q, busy_q;
  logic              win_c;

  // Winner: a lone request wins; on a tie the side that did not go last wins
  assign win_c = (bus.req0 && bus.req1) ? ~last_owner_q : bus.req1;

  // Sequencer plus all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      rfa_q        <= '0;
      rfb_q        <= '0;
      immed_q      <= '0;
      bsel_q       <= 1'b0;
      func_q       <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      res_q        <= '0;
      res_zero_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state_q      <= EXEC;
            owner_q      <= win_c;
            last_owner_q <= win_c;
            gnt0_q       <= ~win_c;
            gnt1_q       <= win_c;
            busy_q       <= 1'b1;
            if (win_c) begin
              rfa_q   <= bus.a1;
              rfb_q   <= bus.b1;
              immed_q <= bus.imm1;
              bsel_q  <= bus.bsel1;
              func_q  <= bus.func1;
            end else begin
              rfa_q   <= bus.a0;
              rfb_q   <= bus.b0;
              immed_q <= bus.imm0;
              bsel_q  <= bus.bsel0;
              func_q  <= bus.func0;
            end
          end
        end
        EXEC: begin
          // ALU stage output is valid now; capture it for the DONE cycle
          state_q    <= DONE;
          gnt0_q     <= 1'b0;
          gnt1_q     <= 1'b0;
          res_q      <= bus.ALU_out;
          res_zero_q <= bus.zero;
          done0_q    <= ~owner_q;
          done1_q    <= owner_q;
        end
        DONE: begin
          state_q <= IDLE;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rfa         = rfa_q;
  assign bus.rfb         = rfb_q;
  assign bus.immed       = immed_q;
  assign bus.ALU_bin_sel = bsel_q;
  assign bus.ALU_func    = func_q;
  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.res         = res_q;
  assign bus.res_zero    = res_zero_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors, a timeline model of the
// arbiter checked every cycle, plus literal expectations per scenario.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;

  alu_arbiter_if #(.DATA_W(32)) bus ();

  alu_arbiter #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU stage stand-in
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] imm, input logic bsel,
                                        input logic [3:0] fn);
    logic [31:0] op2;
    op2 = bsel ? imm : b;
    case (fn)
      4'h0:    return a & op2;
      4'h1:    return a | op2;
      4'h2:    return a + op2;
      4'h6:    return a - op2;
      default: return a ^ op2;
    endcase
  endfunction

  assign bus.ALU_out = alu_f(bus.rfa, bus.rfb, bus.immed, bus.ALU_bin_sel, bus.ALU_func);
  assign bus.zero    = (bus.ALU_out == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- timeline model ----------------
  // Edges are numbered; a grant taken at edge e shows gnt after e, done after
  // e+1, and the arbiter samples requests again only from edge e+3.
  int          m_edge = 0, m_free = 0, m_gnt_e = -100, m_done_e = -100;
  logic        m_owner = 1'b0, m_last = 1'b1;
  logic [31:0] m_rfa = '0, m_rfb = '0, m_imm = '0, m_res = '0;
  logic        m_bsel = 1'b0, m_rz = 1'b0;
  logic [3:0]  m_func = '0;

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return (last == 1'b1) ? 1'b0 : 1'b1;
    return r1 ? 1'b1 : 1'b0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_edge <= 0; m_free <= 0; m_gnt_e <= -100; m_done_e <= -100;
      m_owner <= 1'b0; m_last <= 1'b1;
      m_rfa <= '0; m_rfb <= '0; m_imm <= '0; m_bsel <= 1'b0; m_func <= '0;
      m_res <= '0; m_rz <= 1'b0;
    end else begin
      m_edge <= m_edge + 1;
      if ((m_edge + 1) >= m_free && (bus.req0 || bus.req1)) begin
        if (pick(bus.req0, bus.req1, m_last)) begin
          m_rfa <= bus.a1; m_rfb <= bus.b1; m_imm <= bus.imm1;
          m_bsel <= bus.bsel1; m_func <= bus.func1;
        end else begin
          m_rfa <= bus.a0; m_rfb <= bus.b0; m_imm <= bus.imm0;
          m_bsel <= bus.bsel0; m_func <= bus.func0;
        end
        m_owner  <= pick(bus.req0, bus.req1, m_last);
        m_last   <= pick(bus.req0, bus.req1, m_last);
        m_gnt_e  <= m_edge + 1;
        m_done_e <= m_edge + 2;
        m_free   <= m_edge + 4;
      end
      if ((m_edge + 1) == m_done_e) begin
        m_res <= alu_f(m_rfa, m_rfb, m_imm, m_bsel, m_func);
        m_rz  <= (alu_f(m_rfa, m_rfb, m_imm, m_bsel, m_func) == 32'd0);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic eg, ed;
    eg = (m_edge == m_gnt_e);
    ed = (m_edge == m_done_e);
    chk("gnt0",     32'(bus.gnt0),  32'(eg && !m_owner));
    chk("gnt1",     32'(bus.gnt1),  32'(eg && m_owner));
    chk("done0",    32'(bus.done0), 32'(ed && !m_owner));
    chk("done1",    32'(bus.done1), 32'(ed && m_owner));
    chk("busy",     32'(bus.busy),  32'(eg || ed));
    chk("rfa",      bus.rfa,   m_rfa);
    chk("rfb",      bus.rfb,   m_rfb);
    chk("immed",    bus.immed, m_imm);
    chk("bin_sel",  32'(bus.ALU_bin_sel), 32'(m_bsel));
    chk("func",     32'(bus.ALU_func),    32'(m_func));
    chk("res",      bus.res,   m_res);
    chk("res_zero", 32'(bus.res_zero),    32'(m_rz));
    chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1),   32'd0);
    chk("done_excl",32'(bus.done0 & bus.done1), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.imm0 = 0; bus.bsel0 = 0; bus.func0 = 0;
    bus.a1 = 0; bus.b1 = 0; bus.imm1 = 0; bus.bsel1 = 0; bus.func1 = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int gcyc[$];
    int gown[$];
    int dseen;
    int lat;
    idle_inputs();
    #1 reset = 1'b0;
    cyc(2);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_res",  bus.res, 32'd0);
    reset = 1'b1;
    cyc(1);

    // Single request from requester 0: 5 + 3
    bus.req0 = 1; bus.a0 = 5; bus.b0 = 3; bus.imm0 = 32'h55; bus.bsel0 = 0; bus.func0 = 4'h2;
    cyc(1);
    chk("s_gnt0", 32'(bus.gnt0), 32'd1);
    chk("s_rfa",  bus.rfa, 32'd5);
    chk("s_rfb",  bus.rfb, 32'd3);
    chk("s_func", 32'(bus.ALU_func), 32'd2);
    bus.req0 = 0; bus.a0 = 32'hdead;
    cyc(1);
    chk("s_done0", 32'(bus.done0), 32'd1);
    chk("s_res",   bus.res, 32'd8);
    chk("s_rz",    32'(bus.res_zero), 32'd0);

    // Hold for 10 idle cycles
    cyc(10);
    chk("h_res",  bus.res, 32'd8);
    chk("h_rfa",  bus.rfa, 32'd5);
    chk("h_busy", 32'(bus.busy), 32'd0);

    // Zero flag from requester 1: 7 - imm 7
    bus.req1 = 1; bus.a1 = 7; bus.b1 = 32'd99; bus.imm1 = 7; bus.bsel1 = 1; bus.func1 = 4'h6;
    cyc(1);
    chk("z_gnt1",  32'(bus.gnt1), 32'd1);
    chk("z_immed", bus.immed, 32'd7);
    chk("z_bsel",  32'(bus.ALU_bin_sel), 32'd1);
    bus.req1 = 0;
    cyc(1);
    chk("z_done1", 32'(bus.done1), 32'd1);
    chk("z_res",   bus.res, 32'd0);
    chk("z_rz",    32'(bus.res_zero), 32'd1);
    cyc(2);

    // Reset while in EXEC
    bus.req0 = 1; bus.a0 = 32'h11; bus.b0 = 32'h22; bus.func0 = 4'h1; bus.bsel0 = 0;
    cyc(1);
    chk("r_gnt0", 32'(bus.gnt0), 32'd1);
    bus.req0 = 0;
    #2 reset = 1'b0;
    #1;
    chk("r_gnt0_clr", 32'(bus.gnt0), 32'd0);
    chk("r_busy",     32'(bus.busy), 32'd0);
    chk("r_rfa",      bus.rfa, 32'd0);
    chk("r_res",      bus.res, 32'd0);
    chk("r_rz",       32'(bus.res_zero), 32'd1 - 32'd1);
    cyc(1);
    reset = 1'b1;
    dseen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (bus.done0 || bus.done1) dseen++;
    end
    chk("r_no_done", 32'(dseen), 32'd0);

    // Tie after reset: 0,1,0,1 every third cycle
    bus.req0 = 1; bus.req1 = 1;
    bus.a0 = 32'd10; bus.b0 = 32'd1; bus.func0 = 4'h2;
    bus.a1 = 32'd20; bus.b1 = 32'd4; bus.func1 = 4'h6;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (bus.gnt0) begin gcyc.push_back(i); gown.push_back(0); end
      if (bus.gnt1) begin gcyc.push_back(i); gown.push_back(1); end
    end
    bus.req0 = 0; bus.req1 = 0;
    chk("t_count", 32'(gcyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < gcyc.size(); i++) begin
      chk($sformatf("t_cyc%0d", i), 32'(gcyc[i]), 32'(1 + 3 * i));
      chk($sformatf("t_own%0d", i), 32'(gown[i]), 32'(i % 2));
    end
    cyc(4);

    // Late request from 1 during EXEC of 0
    bus.req0 = 1; bus.a0 = 32'd5; bus.b0 = 32'd3; bus.func0 = 4'h2;
    cyc(1);
    chk("l_gnt0", 32'(bus.gnt0), 32'd1);
    bus.req0 = 0; bus.req1 = 1; bus.a1 = 32'd9; bus.bsel1 = 0; bus.b1 = 32'd9; bus.func1 = 4'h0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (bus.gnt1 && lat == 0) begin
        lat = i;
        bus.req1 = 0;
      end
    end
    bus.req1 = 0;
    chk("l_latency", 32'(lat), 32'd3);
    cyc(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
